// File: rtl/egress_reader.sv
// rtl/egress_reader.sv - round-robin merge of two source FIFOs into one valid/ready output stream.
// Optional destination check built when EGRESS_DEST_CHECK_EN is defined.
module egress_reader #(
   parameter int BW    = 6,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             D0_empty,
   input  logic             D1_empty,
   input  logic             D0_error_output,
   input  logic             D1_error_output,
   input  logic [BW-1:0]    D0_data_out,
   input  logic [BW-1:0]    D1_data_out,
   output logic             D0_rd,
   output logic             D1_rd,
   input  logic             out_ready,
   output logic             out_valid,
   output logic [BW-1:0]    out_data,
   output logic             out_src,
   output logic [CNT_W-1:0] cnt_D0,
   output logic [CNT_W-1:0] cnt_D1,
   output logic             idle_out
`ifdef EGRESS_DEST_CHECK_EN
   ,
   output logic             dest_err,
   output logic [CNT_W-1:0] dest_err_cnt
`endif
);

   typedef enum logic [1:0] {IDLE, CAP, OUT} state_t;

   state_t        state, state_nx;
   logic          last_src;
   logic          sel_q;
   logic          elig0, elig1, any_elig, pick, issue;
   logic [BW-1:0] cap_word;

   assign elig0    = !D0_empty && !D0_error_output;
   assign elig1    = !D1_empty && !D1_error_output;
   assign any_elig = elig0 || elig1;
   // On a tie the source not served last wins; otherwise the lone eligible one.
   assign pick     = (elig0 && elig1) ? ~last_src : elig1;
   assign cap_word = sel_q ? D1_data_out : D0_data_out;

   always_comb begin
      state_nx = state;
      issue    = 1'b0;
      case (state)
         IDLE: begin
            if (any_elig) begin
               issue    = 1'b1;
               state_nx = CAP;
            end
         end
         CAP: state_nx = OUT;
         OUT: begin
            if (out_ready) begin
               if (any_elig) begin
                  issue    = 1'b1;
                  state_nx = CAP;
               end else begin
                  state_nx = IDLE;
               end
            end
         end
         default: state_nx = IDLE;
      endcase
      if (reset) issue = 1'b0;
   end

   assign D0_rd    = issue && !pick;
   assign D1_rd    = issue && pick;
   assign idle_out = (state == IDLE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_src   <= 1'b0;
         cnt_D0    <= '0;
         cnt_D1    <= '0;
         last_src  <= 1'b1;
         sel_q     <= 1'b0;
      end else begin
         state <= state_nx;
         if (issue) begin
            sel_q    <= pick;
            last_src <= pick;
         end
         if (state == CAP) begin
            out_data  <= cap_word;
            out_src   <= sel_q;
            out_valid <= 1'b1;
         end else if (state == OUT && out_ready) begin
            // Drop valid on accept so the CAP cycle never re-presents the old word.
            out_valid <= 1'b0;
            if (out_src) cnt_D1 <= cnt_D1 + CNT_W'(1);
            else         cnt_D0 <= cnt_D0 + CNT_W'(1);
         end
      end
   end

`ifdef EGRESS_DEST_CHECK_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         dest_err     <= 1'b0;
         dest_err_cnt <= '0;
      end else begin
         dest_err <= (state == CAP) && (cap_word[BW-3] != sel_q);
         if (state == CAP && cap_word[BW-3] != sel_q)
            dest_err_cnt <= dest_err_cnt + CNT_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_egress_reader.sv
// tb/tb_egress_reader.sv - scoreboard bench for egress_reader; set EGRESS_DEST_CHECK_EN to cover the destination check.
module tb_egress_reader;
   localparam int BW    = 6;
   localparam int CNT_W = 8;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             D0_empty = 1'b1, D1_empty = 1'b1;
   logic             D0_error_output = 1'b0, D1_error_output = 1'b0;
   logic [BW-1:0]    D0_data_out = '0, D1_data_out = '0;
   logic             D0_rd, D1_rd;
   logic             out_ready = 1'b1;
   logic             out_valid;
   logic [BW-1:0]    out_data;
   logic             out_src;
   logic [CNT_W-1:0] cnt_D0, cnt_D1;
   logic             idle_out;
`ifdef EGRESS_DEST_CHECK_EN
   logic             dest_err;
   logic [CNT_W-1:0] dest_err_cnt;
   int               dest_pulses = 0;
`endif

   egress_reader #(.BW(BW), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset),
      .D0_empty(D0_empty), .D1_empty(D1_empty),
      .D0_error_output(D0_error_output), .D1_error_output(D1_error_output),
      .D0_data_out(D0_data_out), .D1_data_out(D1_data_out),
      .D0_rd(D0_rd), .D1_rd(D1_rd),
      .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
      .cnt_D0(cnt_D0), .cnt_D1(cnt_D1), .idle_out(idle_out)
`ifdef EGRESS_DEST_CHECK_EN
      , .dest_err(dest_err), .dest_err_cnt(dest_err_cnt)
`endif
   );

   always #5 clk = ~clk;

   logic [BW-1:0] q0[$];
   logic [BW-1:0] q1[$];
   logic [BW:0]   expq[$];
   int checks = 0, errors = 0;
   int both_rd = 0, err_rd = 0;

   // Source FIFO models: registered read data, empty flag follows the queue.
   always @(posedge clk) begin
      if (D0_rd && q0.size() > 0) D0_data_out <= q0.pop_front();
      if (D1_rd && q1.size() > 0) D1_data_out <= q1.pop_front();
      D0_empty <= (q0.size() == 0);
      D1_empty <= (q1.size() == 0);
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Monitor: pops the scoreboard on every handshake.
   always @(negedge clk) begin
      if (D0_rd && D1_rd) both_rd++;
      if (D1_rd && D1_error_output) err_rd++;
`ifdef EGRESS_DEST_CHECK_EN
      if (dest_err) dest_pulses++;
`endif
      if (!reset && out_valid && out_ready) begin
         if (expq.size() == 0) chk("unexpected_word", {out_src, out_data}, -1);
         else chk("word_src_data", {out_src, out_data}, expq.pop_front());
      end
   end

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push(input bit src, input logic [BW-1:0] w, input bit expect_out);
      if (src) q1.push_back(w);
      else     q0.push_back(w);
      if (expect_out) expq.push_back({src, w});
   endtask

   task automatic drain(input int budget);
      int n = 0;
      @(negedge clk);
      while ((expq.size() != 0 || !idle_out) && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk("drain_timeout", (n < budget) ? 1 : 0, 1);
      tick(1);
   endtask

   task automatic wait_valid(input int budget);
      int n = 0;
      @(negedge clk);
      while (!out_valid && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk("valid_timeout", (n < budget) ? 1 : 0, 1);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick(2);
      reset = 1'b0;
   endtask

   initial begin
      logic [BW-1:0] held;
      int stall_bad;

      // Single word from D0, pushed under reset to check rd gating.
      reset = 1'b1;
      tick(1);
      push(1'b0, 6'b00_0101, 1'b1);
      tick(2);
      @(negedge clk);
      chk("reset_rd_gated", {D0_rd, D1_rd}, 0);
      chk("reset_out_valid", out_valid, 0);
      chk("reset_out_data", out_data, 0);
      chk("reset_cnt", {cnt_D0, cnt_D1}, 0);
      chk("reset_idle", idle_out, 1);
      tick(1);
      reset = 1'b0;
      drain(50);
      chk("single_cnt_D0", cnt_D0, 1);
      chk("single_cnt_D1", cnt_D1, 0);

      // Three words in each FIFO: strict alternation starting with D0.
      reset = 1'b1;
      tick(1);
      for (int i = 0; i < 3; i++) begin
         push(1'b0, BW'(6'h11 + i), 1'b1);
         push(1'b1, BW'(6'h21 + i), 1'b1);
      end
      tick(2);
      reset = 1'b0;
      drain(100);
      chk("rr_cnt_D0", cnt_D0, 3);
      chk("rr_cnt_D1", cnt_D1, 3);
      chk("rr_both_rd", both_rd, 0);

      // Stall: output held, no reads while another source waits.
      out_ready = 1'b0;
      push(1'b1, 6'h2A, 1'b1);
      wait_valid(20);
      tick(1);
      push(1'b0, 6'h05, 1'b1);
      held = out_data;
      stall_bad = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (out_data != held || !out_valid || D0_rd || D1_rd) stall_bad++;
      end
      chk("stall_stable_no_rd", stall_bad, 0);
      chk("stall_cnt_D1_before", cnt_D1, 3);
      tick(1);
      out_ready = 1'b1;
      drain(50);
      chk("stall_cnt_D1_after", cnt_D1, 4);
      chk("stall_cnt_D0_after", cnt_D0, 4);

      // D1 in error: only D0 drains.
      D1_error_output = 1'b1;
      push(1'b1, 6'h31, 1'b0);
      push(1'b1, 6'h32, 1'b0);
      push(1'b0, 6'h01, 1'b1);
      push(1'b0, 6'h02, 1'b1);
      drain(60);
      tick(5);
      chk("err_no_D1_rd", err_rd, 0);
      chk("err_q1_left", q1.size(), 2);
      chk("err_cnt_D0", cnt_D0, 6);
      chk("err_cnt_D1", cnt_D1, 4);
      reset = 1'b1;
      q1.delete();
      D1_error_output = 1'b0;
      tick(2);
      reset = 1'b0;

      // Counter wrap on D0.
      for (int i = 0; i < 255; i++) push(1'b0, BW'(i), 1'b1);
      drain(2000);
      chk("wrap_cnt_255", cnt_D0, 255);
      push(1'b0, 6'h3F, 1'b1);
      drain(50);
      chk("wrap_cnt_0", cnt_D0, 0);

      // Reset while a word is held in OUT.
      push(1'b1, 6'h2C, 1'b1);
      drain(50);
      chk("mid_cnt_D1_pre", cnt_D1, 1);
      out_ready = 1'b0;
      push(1'b0, 6'h15, 1'b0);
      wait_valid(20);
      tick(1);
      reset = 1'b1;
      tick(1);
      @(negedge clk);
      chk("mid_reset_valid", out_valid, 0);
      chk("mid_reset_cnts", {cnt_D0, cnt_D1}, 0);
      reset = 1'b0;
      out_ready = 1'b1;
      tick(5);
      chk("mid_reset_cnt_D0", cnt_D0, 0);

`ifdef EGRESS_DEST_CHECK_EN
      do_reset();
      dest_pulses = 0;
      push(1'b0, 6'b00_1000, 1'b1);
      drain(50);
      chk("dest_pulse_bad", dest_pulses, 1);
      chk("dest_cnt_bad", dest_err_cnt, 1);
      push(1'b0, 6'b00_0000, 1'b1);
      drain(50);
      chk("dest_pulse_good", dest_pulses, 1);
      chk("dest_cnt_good", dest_err_cnt, 1);
`endif

      chk("scoreboard_empty", expq.size(), 0);
      chk("never_both_rd", both_rd, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL global_timeout: got 1 expected 0");
      $fatal(1, "timeout");
   end
endmodule
